pipelined_instruction_decoder: RTL and testbench

- Registered, handshaked successor to the combinational null-instruction decoder.
- Accepts one instruction per handshake and decodes it into ALU control fields held in an output register.
- Memory and stack operations are held until the memory system reports completion, with a timeout.
- Sits between instruction fetch and the ALU/register-file datapath.
- Data width, register-select width, opcode width and memory timeout are parametrised.

---
 rtl/pipelined_instruction_decoder_if.sv | 42 ++++
 rtl/pipelined_instruction_decoder.sv | 153 +++++++++++++++
 tb/tb_pipelined_instruction_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_instruction_decoder_if.sv
// pipelined_instruction_decoder_if: fetch-side handshake and ALU control bundle for the decoder
interface pipelined_instruction_decoder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int OP_WIDTH   = 4
);
    localparam int IW = OP_WIDTH + 2 * SEL_WIDTH;
    logic [IW-1:0]         instruction;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] switches;
    logic                  out_valid;
    logic                  out_ready;
    logic                  mem_done;
    logic                  pc_increment;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a_altern;
    logic [DATA_WIDTH-1:0] alu_b_altern;
    logic [SEL_WIDTH-1:0]  alu_a_select;
    logic [SEL_WIDTH-1:0]  alu_b_select;
    logic [SEL_WIDTH-1:0]  alu_out_select;
    logic                  alu_a_source;
    logic                  alu_b_source;
    logic [1:0]            alu_load_src;
    logic                  alu_store_to_mem;
    logic                  alu_store_to_stk;
    logic                  mem_timeout;

    modport master (
        output instruction, in_valid, switches, out_ready, mem_done,
        input  in_ready, out_valid, pc_increment, alu_op, alu_a_altern, alu_b_altern,
               alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_b_source,
               alu_load_src, alu_store_to_mem, alu_store_to_stk, mem_timeout
    );

    modport slave (
        input  instruction, in_valid, switches, out_ready, mem_done,
        output in_ready, out_valid, pc_increment, alu_op, alu_a_altern, alu_b_altern,
               alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_b_source,
               alu_load_src, alu_store_to_mem, alu_store_to_stk, mem_timeout
    );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder: registered, handshaked decode of {opcode, f1, f2} into ALU control fields
module pipelined_instruction_decoder #(
    parameter int DATA_WIDTH  = 16,
    parameter int SEL_WIDTH   = 4,
    parameter int OP_WIDTH    = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input logic clk,
    input logic reset_n,
    pipelined_instruction_decoder_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    logic [OP_WIDTH-1:0]   opc;
    logic [SEL_WIDTH-1:0]  f1, f2;
    logic                  in_ready, out_valid, accept;
    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0] a_altern_q, a_altern_d;
    logic [SEL_WIDTH-1:0]  a_sel_q, a_sel_d;
    logic [SEL_WIDTH-1:0]  b_sel_q, b_sel_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
    logic                  a_src_q, a_src_d;
    logic [1:0]            load_q, load_d;
    logic                  st_mem_q, st_mem_d;
    logic                  st_stk_q, st_stk_d;
    logic                  is_mem_q, is_mem_d;

    assign {opc, f1, f2} = bus.instruction;
    assign out_valid = state_q == HOLD;
    // a memory/stack op must drain through MEM_WAIT, so it cannot be overlapped with a new accept
    assign in_ready  = state_q == IDLE || (out_valid && bus.out_ready && !is_mem_q);
    assign accept    = bus.in_valid && in_ready;

    // decode the incoming instruction; anything not listed is a noop with all fields zero
    always_comb begin
        op_d       = '0;
        a_altern_d = '0;
        a_sel_d    = '0;
        b_sel_d    = '0;
        out_sel_d  = '0;
        a_src_d    = 1'b0;
        load_d     = 2'b00;
        st_mem_d   = 1'b0;
        st_stk_d   = 1'b0;
        is_mem_d   = 1'b0;
        if (opc == OP_WIDTH'(1)) begin
            op_d       = OP_WIDTH'(f1);
            a_altern_d = bus.switches;
            a_src_d    = 1'b1;
            b_sel_d    = f2;
            out_sel_d  = f2;
            load_d     = 2'b01;
        end else if (opc[3]) begin
            is_mem_d  = 1'b1;
            a_sel_d   = f1;
            out_sel_d = f2;
            op_d      = opc[0] ? OP_WIDTH'(1) : '0;
            b_sel_d   = opc[0] ? f2 : '0;
            load_d    = opc[2] ? 2'b01 : {1'b1, opc[1]};
            st_stk_d  = opc[2] && opc[1];
            st_mem_d  = opc[2] && !opc[1];
        end
    end

    // handshake state machine with memory-completion timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            if (accept) state_d = HOLD;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) begin
                if (is_mem_q) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end else if (!accept) begin
                    state_d = IDLE;
                end
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_done) begin
                state_d = IDLE;
            end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                state_d   = IDLE;
                timeout_d = 1'b1;
            end
        end
    end

    // state, counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // control fields and switch snapshot captured only on accept, otherwise held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= '0;
            a_altern_q <= '0;
            a_sel_q    <= '0;
            b_sel_q    <= '0;
            out_sel_q  <= '0;
            a_src_q    <= 1'b0;
            load_q     <= 2'b00;
            st_mem_q   <= 1'b0;
            st_stk_q   <= 1'b0;
            is_mem_q   <= 1'b0;
        end else if (accept) begin
            op_q       <= op_d;
            a_altern_q <= a_altern_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            out_sel_q  <= out_sel_d;
            a_src_q    <= a_src_d;
            load_q     <= load_d;
            st_mem_q   <= st_mem_d;
            st_stk_q   <= st_stk_d;
            is_mem_q   <= is_mem_d;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid;
    assign bus.pc_increment     = out_valid;
    assign bus.alu_op           = op_q;
    assign bus.alu_a_altern     = a_altern_q;
    assign bus.alu_b_altern     = '0;
    assign bus.alu_a_select     = a_sel_q;
    assign bus.alu_b_select     = b_sel_q;
    assign bus.alu_out_select   = out_sel_q;
    assign bus.alu_a_source     = a_src_q;
    assign bus.alu_b_source     = 1'b0;
    assign bus.alu_load_src     = load_q;
    assign bus.alu_store_to_mem = st_mem_q && out_valid;
    assign bus.alu_store_to_stk = st_stk_q && out_valid;
    assign bus.mem_timeout      = timeout_q;
endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// tb_pipelined_instruction_decoder: directed vectors with hand-computed expectations
module tb_pipelined_instruction_decoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pipelined_instruction_decoder_if #(.DATA_WIDTH(16), .SEL_WIDTH(4), .OP_WIDTH(4)) bus ();

    pipelined_instruction_decoder #(
        .DATA_WIDTH(16), .SEL_WIDTH(4), .OP_WIDTH(4), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] noops [3];
        noops = '{4'b0010, 4'b0011, 4'b0101};
        bus.instruction = '0;
        bus.in_valid    = 1'b0;
        bus.switches    = '0;
        bus.out_ready   = 1'b0;
        bus.mem_done    = 1'b0;
        step();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_pc", bus.pc_increment, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_timeout", bus.mem_timeout, 0);
        reset_n = 1'b1;
        step();

        // noop class
        bus.instruction = 12'h000;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b1;
        step();
        check("ujmp_valid", bus.out_valid, 1);
        check("ujmp_pc", bus.pc_increment, 1);
        check("ujmp_load", bus.alu_load_src, 0);
        check("ujmp_stores", {bus.alu_store_to_mem, bus.alu_store_to_stk}, 0);
        foreach (noops[i]) begin
            bus.instruction = {noops[i], 8'h5A};
            step();
            check("noop_valid", bus.out_valid, 1);
            check("noop_pc", bus.pc_increment, 1);
            check("noop_fields", {bus.alu_op, bus.alu_a_select, bus.alu_out_select, bus.alu_load_src}, 0);
        end
        bus.in_valid = 1'b0;
        step();
        check("noop_drop_valid", bus.out_valid, 0);
        check("noop_drop_pc", bus.pc_increment, 0);

        // ldsw with switch snapshot, held under back-pressure
        bus.switches    = 16'h1242;
        bus.instruction = 12'h1B7;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        step();
        bus.in_valid = 1'b0;
        bus.switches = 16'hFFFF;
        check("ldsw_op", bus.alu_op, 4'hB);
        check("ldsw_altern", bus.alu_a_altern, 16'h1242);
        check("ldsw_src", {bus.alu_a_source, bus.alu_b_source}, 2'b10);
        check("ldsw_sel", {bus.alu_b_select, bus.alu_out_select}, 8'h77);
        check("ldsw_load", bus.alu_load_src, 2'b01);
        check("ldsw_b_altern", bus.alu_b_altern, 0);
        step();
        check("ldsw_snapshot", bus.alu_a_altern, 16'h1242);
        check("ldsw_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();
        check("ldsw_done_valid", bus.out_valid, 0);
        check("ldsw_field_kept", bus.alu_op, 4'hB);

        // memory store, completion after three MEM_WAIT cycles
        bus.instruction = 12'hD01;
        bus.in_valid    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("stm_op", bus.alu_op, 1);
        check("stm_sel", {bus.alu_a_select, bus.alu_b_select, bus.alu_out_select}, 12'h011);
        check("stm_load", bus.alu_load_src, 2'b01);
        check("stm_stores", {bus.alu_store_to_mem, bus.alu_store_to_stk}, 2'b10);
        check("stm_hold_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stm_wait_ready", bus.in_ready, 0);
            check("stm_wait_valid", bus.out_valid, 0);
        end
        check("stm_wait_store", bus.alu_store_to_mem, 0);
        bus.mem_done = 1'b1;
        step();
        bus.mem_done = 1'b0;
        check("stm_done_ready", bus.in_ready, 1);
        check("stm_no_timeout", bus.mem_timeout, 0);

        // stack read under five cycles of back-pressure
        bus.instruction = 12'hB01;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stk_valid", bus.out_valid, 1);
            check("stk_fields", {bus.alu_op, bus.alu_b_select, bus.alu_load_src}, {4'h1, 4'h1, 2'b11});
            check("stk_stores", {bus.alu_store_to_mem, bus.alu_store_to_stk}, 0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("stk_wait_valid", bus.out_valid, 0);
        bus.mem_done = 1'b1;
        step();
        bus.mem_done = 1'b0;
        check("stk_done_ready", bus.in_ready, 1);

        // back-to-back ldsw
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instruction = {4'b0001, 4'(i), 4'(i + 1)};
            bus.switches    = 16'(i * 16'h111);
            step();
            check("b2b_valid", bus.out_valid, 1);
            check("b2b_op", bus.alu_op, i);
            check("b2b_altern", bus.alu_a_altern, i * 16'h111);
            check("b2b_out_sel", bus.alu_out_select, i + 1);
        end
        bus.in_valid = 1'b0;
        step();
        check("b2b_end_valid", bus.out_valid, 0);

        // mem_done on the timeout cycle wins
        bus.instruction = 12'h823;
        bus.in_valid    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("ld_load", bus.alu_load_src, 2'b10);
        check("ld_sel", {bus.alu_op, bus.alu_a_select, bus.alu_b_select, bus.alu_out_select}, 16'h0203);
        step();
        for (int i = 0; i < 7; i++) step();
        bus.mem_done = 1'b1;
        step();
        bus.mem_done = 1'b0;
        check("tie_no_timeout", bus.mem_timeout, 0);
        check("tie_ready", bus.in_ready, 1);

        // genuine timeout after eight MEM_WAIT cycles
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        for (int i = 0; i < 7; i++) step();
        check("to_still_waiting", bus.in_ready, 0);
        check("to_not_yet", bus.mem_timeout, 0);
        step();
        check("to_flag", bus.mem_timeout, 1);
        check("to_idle", bus.in_ready, 1);
        bus.mem_done = 1'b1;
        step();
        bus.mem_done = 1'b0;
        check("to_sticky", bus.mem_timeout, 1);

        // reset in the middle of HOLD discards the instruction
        bus.instruction = 12'h1B7;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_op", bus.alu_op, 0);
        check("mid_rst_timeout", bus.mem_timeout, 0);
        check("mid_rst_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        step();
        check("post_rst_valid", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
